// File: rtl/avmm_arb_pkg.sv
// avmm_arb_pkg
// Shared types and defaults for the Avalon-MM write arbiter.
//   arb_state_t : arbiter FSM state encoding
//   DEF_*       : default address/data widths and abort timeout
//   clog2_safe  : index width helper that never returns 0
package avmm_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 50000000;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avmm_write_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector. The search starts one past the last
// served index and wraps, so the last winner has the lowest priority.
// Ports:
//   i_req   : request vector, one bit per requester
//   i_last  : index served most recently
//   o_grant : one-hot winner (all zero when no request)
//   o_idx   : winner index
//   o_any   : at least one request pending
module rr_pick
  import avmm_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2_safe(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    int pos;
    pos     = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = (int'(i_last) + k) % N_REQ;
      if (!o_any && i_req[pos[IW-1:0]]) begin
        o_any                = 1'b1;
        o_idx                = pos[IW-1:0];
        o_grant[pos[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avmm_write_arbiter.sv
// avmm_write_arbiter
// Shares one Avalon-MM write master between N_REQ requesters. Round-robin
// grant, address/data latched at grant, one downstream write per grant,
// completion returned only to the granted requester.
// Optional feature macro: AVMM_ARB_TIMEOUT_EN (abort a write stalled for
// TIMEOUT waitrequest cycles and pulse timeout_err).
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   req_write/address/... : packed per-requester slave inputs
//   req_waitrequest       : per-requester stall (low only on completion)
//   avmm_*                : downstream master port
//   grant_id              : current or last granted requester
//   busy                  : transaction in flight
//   timeout_err           : one-cycle abort pulse
//
// state | meaning
// IDLE  | no write in flight; arbitrate and latch the winner
// BUSY  | downstream write asserted; wait for waitrequest low
module avmm_write_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  AW      = DEF_AW,
  parameter int  DW      = DEF_DW,
  parameter int  TIMEOUT = DEF_TIMEOUT,
  localparam int IW      = clog2_safe(N_REQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_REQ-1:0]  req_write,
  input  logic [N_REQ*AW-1:0] req_address,
  input  logic [N_REQ*DW-1:0] req_writedata,
  output logic [N_REQ-1:0]  req_waitrequest,
  output logic              avmm_write,
  output logic [AW-1:0]     avmm_address,
  output logic [DW-1:0]     avmm_writedata,
  input  logic              avmm_waitrequest,
  output logic [IW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_err
);

  arb_state_t r_state, w_next;
  logic [IW-1:0]    r_grant, r_last;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_data;
  logic [N_REQ-1:0] w_pick_oh;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_data;
  logic             w_done;
  logic             w_abort;
  logic             w_to_hit;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .i_req   (req_write),
    .i_last  (r_last),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // AND-OR mux keyed by the one-hot winner
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_oh[i]) begin
        w_sel_addr = w_sel_addr | req_address[i*AW +: AW];
        w_sel_data = w_sel_data | req_writedata[i*DW +: DW];
      end
    end
  end

`ifdef AVMM_ARB_TIMEOUT_EN
  localparam int CW = clog2_safe(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (avmm_waitrequest && !w_to_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_to_hit = (r_state == BUSY) && avmm_waitrequest &&
                    (r_cnt == CW'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_to_hit         = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_done  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) w_next = BUSY;
      end
      BUSY: begin
        if (!avmm_waitrequest) begin
          w_next = IDLE;
          w_done = 1'b1;
        end else if (w_to_hit) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(N_REQ - 1);
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_pick_any) begin
        r_grant <= w_pick_idx;
        r_addr  <= w_sel_addr;
        r_data  <= w_sel_data;
      end
      if (w_done || w_abort) r_last <= r_grant;
    end
  end

  // Release only the granted requester, on completion or abort
  always_comb begin
    req_waitrequest = '1;
    if (w_done || w_abort) req_waitrequest[r_grant] = 1'b0;
  end

  // Decoded from state so an async reset drops the strobe immediately
  assign avmm_write     = (r_state == BUSY);
  assign busy           = (r_state == BUSY);
  assign avmm_address   = r_addr;
  assign avmm_writedata = r_data;
  assign grant_id       = r_grant;
  assign timeout_err    = w_abort;

endmodule

// File: tb/tb_avmm_write_arbiter.sv
module tb_avmm_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_writedata;
  logic [N-1:0]    req_waitrequest;
  logic            avmm_write;
  logic [AW-1:0]   avmm_address;
  logic [DW-1:0]   avmm_writedata;
  logic            avmm_waitrequest;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  avmm_write_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_write        (req_write),
    .req_address      (req_address),
    .req_writedata    (req_writedata),
    .req_waitrequest  (req_waitrequest),
    .avmm_write       (avmm_write),
    .avmm_address     (avmm_address),
    .avmm_writedata   (avmm_writedata),
    .avmm_waitrequest (avmm_waitrequest),
    .grant_id         (grant_id),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_address[i*AW +: AW]   = a;
    req_writedata[i*DW +: DW] = d;
  endtask

  int rr_exp [5] = '{3, 0, 1, 2, 3};

  initial begin
    reset_n          = 1'b0;
    req_write        = '0;
    req_address      = '0;
    req_writedata    = '0;
    avmm_waitrequest = 1'b0;
    #12;
    chk("rst_write", avmm_write, 0);
    chk("rst_addr", avmm_address, 0);
    chk("rst_data", avmm_writedata, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_toerr", timeout_err, 0);
    chk("rst_reqwait", req_waitrequest, 4'hF);
    tick();
    reset_n = 1'b1;
    tick();

    // single request from requester 2
    set_req(2, 32'h0000_1000, 32'hDEAD_BEEF);
    req_write = 4'b0100;
    #1;
    chk("idle_write", avmm_write, 0);
    tick();
    chk("s_write", avmm_write, 1);
    chk("s_addr", avmm_address, 32'h0000_1000);
    chk("s_data", avmm_writedata, 32'hDEAD_BEEF);
    chk("s_reqwait", req_waitrequest, 4'b1011);
    chk("s_grant", grant_id, 2);
    chk("s_busy", busy, 1);
    req_write = 4'b0000;
    tick();
    chk("s_idle_write", avmm_write, 0);
    chk("s_idle_grant", grant_id, 2);
    chk("s_idle_reqwait", req_waitrequest, 4'hF);
    chk("s_idle_addr_hold", avmm_address, 32'h0000_1000);

    // round robin, all requesting, pointer starts after requester 2
    for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), 32'hC0DE_0000 + i);
    req_write = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_write", avmm_write, 1);
      chk("rr_grant", grant_id, rr_exp[k]);
      chk("rr_addr", avmm_address, 32'h100 * (rr_exp[k] + 1));
      tick();
      chk("rr_gap", avmm_write, 0);
    end

    // stall on requester 1
    set_req(1, 32'hA000_0010, 32'h1111_2222);
    req_write        = 4'b0010;
    avmm_waitrequest = 1'b1;
    tick();
    chk("st_grant", grant_id, 1);
    set_req(1, 32'h0000_0BAD, 32'h0BAD_0BAD);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      chk("st_write", avmm_write, 1);
      chk("st_reqwait", req_waitrequest, 4'hF);
      chk("st_addr", avmm_address, 32'hA000_0010);
    end
    tick();
    avmm_waitrequest = 1'b0;
    #1;
    chk("st6_write", avmm_write, 1);
    chk("st6_reqwait", req_waitrequest, 4'b1101);
    chk("st6_data", avmm_writedata, 32'h1111_2222);
    req_write = 4'b0000;
    tick();
    chk("st_end_write", avmm_write, 0);

    // requester 3 arrives in requester 0's completion cycle
    set_req(0, 32'h0000_0A00, 32'h0000_00A0);
    set_req(3, 32'h0000_0D00, 32'h0000_00D0);
    req_write = 4'b0001;
    tick();
    chk("ov_grant0", grant_id, 0);
    req_write = 4'b1001;
    tick();
    chk("ov_idle", avmm_write, 0);
    tick();
    chk("ov_grant3", grant_id, 3);
    chk("ov_addr3", avmm_address, 32'h0000_0D00);
    req_write = 4'b0001;
    tick();
    tick();
    chk("ov_grant0_again", grant_id, 0);

    // reset in the middle of a stalled write
    avmm_waitrequest = 1'b1;
    req_write        = 4'b0000;
    tick();
    chk("rm_write_pre", avmm_write, 1);
    reset_n = 1'b0;
    #1;
    chk("rm_write", avmm_write, 0);
    chk("rm_busy", busy, 0);
    chk("rm_reqwait", req_waitrequest, 4'hF);
    chk("rm_grant", grant_id, 0);
    tick();
    reset_n          = 1'b1;
    avmm_waitrequest = 1'b0;
    req_write        = 4'hF;
    tick();
    chk("rm_first", grant_id, 0);
    chk("rm_first_addr", avmm_address, 32'h0000_0A00);
    tick();
    tick();
    chk("rm_second", grant_id, 1);
    chk("rm_toerr", timeout_err, 0);
    req_write = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
